// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the pong game sequencer: state codes and a
// decimal-to-BCD helper used to turn the score limit into counter format.
package game_ctrl_pkg;

    // State codes also used by the overlay and graphics stages.
    typedef enum logic [1:0] {
        ST_PLAY    = 2'b00,
        ST_NEWBALL = 2'b01,
        ST_OVER    = 2'b10,
        ST_NEWGAME = 2'b11
    } state_t;

    localparam int TIMER_W = 7;

    // Convert a decimal value 0..99 into two packed BCD digits {tens, units}.
    function automatic logic [7:0] to_bcd8(input int v);
        to_bcd8 = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/game_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear and saturation at a
// BCD-encoded maximum. Clear wins over increment.
module bcd2_counter
    import game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] max,
    output logic [3:0] dig1,
    output logic [3:0] dig0
);

    // BCD ordering matches numeric ordering, so a plain compare finds saturation.
    logic w_at_max;
    assign w_at_max = ({dig1, dig0} >= max);

    // Score digits: clear, or increment with units-to-tens carry, holding at max.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            dig1 <= 4'd0;
            dig0 <= 4'd0;
        end else if (inc && !w_at_max) begin
            if (dig0 == 4'd9) begin
                dig0 <= 4'd0;
                dig1 <= dig1 + 4'd1;
            end else begin
                dig0 <= dig0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer and score keeper. Holds the game FSM, button edge
// detector, the NEWBALL/OVER wait timer and the ball counter; the score
// lives in a saturating BCD counter. All outputs are registered.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120,
    parameter int SCORE_MAX   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    input  logic       btn,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic [1:0] state,
    output logic       graph_still
);

    // hit/miss/refr_tick are single-clock pulses; btn is a level and only its
    // rising edge (one per hold) counts as a press.

    localparam logic [1:0]         BALLS_L = 2'(BALLS);
    localparam logic [TIMER_W-1:0] TICKS_L = TIMER_W'(TIMER_TICKS);
    localparam logic [7:0]         MAX_BCD = to_bcd8(SCORE_MAX);

    state_t             r_state;
    logic [1:0]         r_ball;
    logic               r_graph_still;
    logic               r_btn_q;
    logic [TIMER_W-1:0] r_timer;

    logic w_press;
    logic w_done;
    logic w_start;
    logic w_score_inc;
    logic w_score_clr;

    assign w_press     = btn & ~r_btn_q;
    assign w_done      = (r_timer == '0);
    assign w_start     = (r_state == ST_PLAY) & miss;
    assign w_score_inc = (r_state == ST_PLAY) & hit & ~miss;
    assign w_score_clr = (r_state == ST_NEWGAME) & w_press;

    // Button history for edge detection; cleared so a held button re-presses after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= btn;
        end
    end

    // Wait timer: load on a miss, otherwise count frames down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= TICKS_L;
        end else if (refr_tick && !w_done) begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end

    // Game FSM with ball counter; graph_still tracks whether the next state is PLAY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_NEWGAME;
            r_ball        <= BALLS_L;
            r_graph_still <= 1'b1;
        end else begin
            case (r_state)
                ST_NEWGAME: begin
                    if (w_press) begin
                        r_ball        <= BALLS_L;
                        r_state       <= ST_PLAY;
                        r_graph_still <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (miss) begin
                        r_graph_still <= 1'b1;
                        if (r_ball > 2'd1) begin
                            r_ball  <= r_ball - 2'd1;
                            r_state <= ST_NEWBALL;
                        end else begin
                            r_ball  <= 2'd0;
                            r_state <= ST_OVER;
                        end
                    end
                end
                ST_NEWBALL: begin
                    if (w_press && w_done) begin
                        r_state       <= ST_PLAY;
                        r_graph_still <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (w_done) begin
                        r_state <= ST_NEWGAME;
                        r_ball  <= BALLS_L;
                    end
                end
                default: begin
                    r_state       <= ST_NEWGAME;
                    r_graph_still <= 1'b1;
                end
            endcase
        end
    end

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (w_score_clr),
        .inc   (w_score_inc),
        .max   (MAX_BCD),
        .dig1  (dig1),
        .dig0  (dig0)
    );

    assign state       = r_state;
    assign ball        = r_ball;
    assign graph_still = r_graph_still;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: table of single-cycle vectors, directed multi-cycle
// sequences with fixed expectations, and randomized traffic checked against
// an integer-level game model through an expected-value queue.
module tb_game_ctrl;

    localparam int BALLS = 3;
    localparam int TICKS = 120;
    localparam int SMAX  = 99;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b0;
    logic       refr_tick = 1'b0;
    logic       hit       = 1'b0;
    logic       miss      = 1'b0;
    logic       btn       = 1'b0;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [1:0] ball;
    logic [1:0] state;
    logic       graph_still;

    game_ctrl #(
        .BALLS       (BALLS),
        .TIMER_TICKS (TICKS),
        .SCORE_MAX   (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refr_tick   (refr_tick),
        .hit         (hit),
        .miss        (miss),
        .btn         (btn),
        .dig0        (dig0),
        .dig1        (dig1),
        .ball        (ball),
        .state       (state),
        .graph_still (graph_still)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int m_state = 3;
    int m_score = 0;
    int m_ball  = BALLS;
    int m_timer = 0;
    bit m_btn_q = 1'b0;

    logic [12:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the game model by one clock using the inputs currently applied.
    task automatic model_step();
        bit press;
        bit done;
        bit start;
        if (reset) begin
            m_state = 3;
            m_score = 0;
            m_ball  = BALLS;
            m_timer = 0;
            m_btn_q = 1'b0;
        end else begin
            press   = btn && !m_btn_q;
            done    = (m_timer == 0);
            start   = 1'b0;
            m_btn_q = btn;
            case (m_state)
                3: if (press) begin
                    m_score = 0;
                    m_ball  = BALLS;
                    m_state = 0;
                end
                0: if (miss) begin
                    start = 1'b1;
                    if (m_ball > 1) begin
                        m_ball  = m_ball - 1;
                        m_state = 1;
                    end else begin
                        m_ball  = 0;
                        m_state = 2;
                    end
                end else if (hit) begin
                    m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
                end
                1: if (press && done) m_state = 0;
                default: if (done) begin
                    m_state = 3;
                    m_ball  = BALLS;
                end
            endcase
            if (start) m_timer = TICKS;
            else if (refr_tick && m_timer > 0) m_timer = m_timer - 1;
        end
        exp_q.push_back({2'(m_state), 4'(m_score / 10), 4'(m_score % 10),
                         2'(m_ball), 1'(m_state != 0)});
    endtask

    // ---------------- driver ----------------
    // One clock: apply inputs, step the model at the edge, compare just after.
    task automatic cyc(input bit r, input bit rt, input bit h, input bit m, input bit b);
        logic [12:0] e;
        reset = r; refr_tick = rt; hit = h; miss = m; btn = b;
        @(posedge clk);
        model_step();
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            check("sb_state", int'(state), int'(e[12:11]));
            check("sb_dig1", int'(dig1), int'(e[10:7]));
            check("sb_dig0", int'(dig0), int'(e[6:3]));
            check("sb_ball", int'(ball), int'(e[2:1]));
            check("sb_graph_still", int'(graph_still), int'(e[0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic press();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_miss();
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic new_game();
        cyc(1, 0, 0, 0, 0);
        press();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst; bit rt; bit h; bit m; bit b;
        int st; int d1; int d0; int bl; int gs;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0,  3, 0, 0, 3, 1};
        tbl[1]  = '{0, 0, 0, 0, 1,  0, 0, 0, 3, 0};
        tbl[2]  = '{0, 0, 1, 0, 1,  0, 0, 1, 3, 0};
        tbl[3]  = '{0, 0, 1, 0, 0,  0, 0, 2, 3, 0};
        tbl[4]  = '{0, 0, 1, 1, 0,  1, 0, 2, 2, 1};
        tbl[5]  = '{0, 0, 0, 0, 1,  1, 0, 2, 2, 1};
        tbl[6]  = '{0, 1, 1, 0, 0,  1, 0, 2, 2, 1};
        tbl[7]  = '{1, 0, 0, 0, 0,  3, 0, 0, 3, 1};
        tbl[8]  = '{0, 0, 1, 0, 0,  3, 0, 0, 3, 1};
        tbl[9]  = '{0, 0, 0, 1, 0,  3, 0, 0, 3, 1};
        tbl[10] = '{0, 0, 0, 0, 1,  0, 0, 0, 3, 0};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].rt, tbl[i].h, tbl[i].m, tbl[i].b);
            check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("tbl%0d_dig1", i), int'(dig1), tbl[i].d1);
            check($sformatf("tbl%0d_dig0", i), int'(dig0), tbl[i].d0);
            check($sformatf("tbl%0d_ball", i), int'(ball), tbl[i].bl);
            check($sformatf("tbl%0d_gs", i), int'(graph_still), tbl[i].gs);
        end
        idle(2);

        // Score counting and BCD carry.
        new_game();
        hits(23);
        check("cnt23_dig1", int'(dig1), 2);
        check("cnt23_dig0", int'(dig0), 3);
        new_game();
        hits(9);
        check("pre09_dig1", int'(dig1), 0);
        check("pre09_dig0", int'(dig0), 9);
        hits(1);
        check("carry_dig1", int'(dig1), 1);
        check("carry_dig0", int'(dig0), 0);

        // Saturation at 99, then simultaneous hit and miss.
        hits(89);
        check("at99_dig1", int'(dig1), 9);
        check("at99_dig0", int'(dig0), 9);
        hits(1);
        check("sat_dig1", int'(dig1), 9);
        check("sat_dig0", int'(dig0), 9);
        cyc(0, 0, 1, 1, 0);
        check("hitmiss_dig0", int'(dig0), 9);
        check("hitmiss_ball", int'(ball), 2);
        check("hitmiss_state", int'(state), 1);

        // NEWBALL wait: presses before the timer expires are ignored.
        ticks(50);
        press();
        check("nb50_state", int'(state), 1);
        ticks(69);
        press();
        check("nb119_state", int'(state), 1);
        ticks(1);
        press();
        check("nb120_state", int'(state), 0);
        check("nb120_gs", int'(graph_still), 0);

        // Held button across timer expiry produces no second press.
        do_miss();
        check("miss2_ball", int'(ball), 1);
        for (int i = 0; i < 1000; i++) cyc(0, (i % 4 == 0), 0, 0, 1);
        check("held_state", int'(state), 1);
        idle(1);
        press();
        check("held_release_state", int'(state), 0);

        // Last ball lost, OVER wait, then back to NEWGAME with score kept.
        do_miss();
        check("over_ball", int'(ball), 0);
        check("over_state", int'(state), 2);
        ticks(119);
        check("over119_state", int'(state), 2);
        ticks(1);
        check("ng_state", int'(state), 3);
        check("ng_ball", int'(ball), 3);
        check("ng_dig1", int'(dig1), 9);
        check("ng_dig0", int'(dig0), 9);
        press();
        check("ng_press_state", int'(state), 0);
        check("ng_press_dig1", int'(dig1), 0);
        check("ng_press_dig0", int'(dig0), 0);

        // Reset in the middle of the OVER wait.
        hits(5);
        do_miss(); ticks(120); press();
        do_miss(); ticks(120); press();
        do_miss();
        check("ov2_state", int'(state), 2);
        ticks(60);
        cyc(1, 0, 0, 0, 0);
        check("rst_state", int'(state), 3);
        check("rst_dig0", int'(dig0), 0);
        check("rst_ball", int'(ball), 3);
        check("rst_gs", int'(graph_still), 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("ng_ignore_state", int'(state), 3);
        check("ng_ignore_ball", int'(ball), 3);
        check("ng_ignore_dig0", int'(dig0), 0);

        // Randomized traffic against the model.
        begin
            bit b;
            b = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) b = ~b;
                cyc(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 24) == 0),
                    b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
